// File: rtl/sum_unfilter_pkg.sv
// rtl/sum_unfilter_pkg.sv - shared types for the two-tap sum inverse filter
package sum_unfilter_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/sum_unfilter.sv
// rtl/sum_unfilter.sv - recovers x[n] = y[n] - x[n-1] from a two-tap summed stream
module sum_unfilter
    import sum_unfilter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             seed_valid_i,
    output logic [CNT_W-1:0] count_o
);

    out_state_e       state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] hist_q;
    logic [CNT_W-1:0] count_q;

    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] hist_eff;
    logic [WIDTH-1:0] data_d;

    assign valid_o  = (state_q == ST_FULL);
    assign ready_o  = !valid_o || ready_i;
    assign data_o   = data_q;
    assign count_o  = count_q;

    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = valid_o && ready_i;

    // A seed arriving with a sample takes precedence over the stored history.
    assign hist_eff = seed_valid_i ? seed_i : hist_q;
    assign data_d   = data_i - hist_eff;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            hist_q  <= '0;
            count_q <= '0;
        end else begin
            if (in_xfer) begin
                data_q  <= data_d;
                hist_q  <= data_d;
                count_q <= count_q + CNT_W'(1);
            end else if (seed_valid_i) begin
                hist_q  <= seed_i;
            end

            case (state_q)
                ST_EMPTY: if (in_xfer)                state_q <= ST_FULL;
                ST_FULL:  if (out_xfer && !in_xfer)   state_q <= ST_EMPTY;
                default:                              state_q <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_unfilter.sv
// tb/tb_sum_unfilter.sv - self-checking bench for sum_unfilter
module tb_sum_unfilter;

    localparam int WIDTH = 16;
    localparam int CNT_W = 32;
    localparam int N_RT  = 1000;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] seed_i;
    logic             seed_valid_i;
    logic [CNT_W-1:0] count_o;

    int errors = 0;
    int checks = 0;

    sum_unfilter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .seed_i       (seed_i),
        .seed_valid_i (seed_valid_i),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] y);
        data_i  = y;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic seed(input logic [WIDTH-1:0] s);
        seed_i       = s;
        seed_valid_i = 1'b1;
        tick();
        seed_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [WIDTH-1:0] xs [N_RT];
    logic [WIDTH-1:0] ys [N_RT];
    logic [CNT_W-1:0] cnt_snap;

    initial begin
        rst = 1'b1; data_i = '0; valid_i = 1'b0; ready_i = 1'b1;
        seed_i = '0; seed_valid_i = 1'b0;
        tick(); tick();
        rst = 1'b0;

        check("reset_valid", 64'(valid_o), 64'd0);
        check("reset_data",  64'(data_o),  64'd0);
        check("reset_count", 64'(count_o), 64'd0);
        check("reset_ready", 64'(ready_o), 64'd1);

        push(16'd5);  check("basic0", 64'(data_o), 64'd5);
        check("basic_valid", 64'(valid_o), 64'd1);
        push(16'd12); check("basic1", 64'(data_o), 64'd7);
        push(16'd20); check("basic2", 64'(data_o), 64'd13);
        check("basic_count", 64'(count_o), 64'd3);

        seed(16'h0001);
        check("seed_keeps_data", 64'(data_o), 64'd13);
        check("seed_keeps_count", 64'(count_o), 64'd3);
        push(16'h0000); check("wrap0", 64'(data_o), 64'hFFFF);
        push(16'h0005); check("wrap1", 64'(data_o), 64'h0006);

        seed(16'd3);
        push(16'd10); check("seed_alone", 64'(data_o), 64'd7);

        cnt_snap = count_o;
        ready_i  = 1'b0;
        data_i   = 16'd100;
        valid_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_ready", 64'(ready_o), 64'd0);
            tick();
            check("bp_hold", 64'(data_o), 64'd7);
            check("bp_count", 64'(count_o), 64'(cnt_snap));
        end
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("bp_release", 64'(data_o), 64'd93);
        check("bp_release_count", 64'(count_o), 64'(cnt_snap + 1));

        seed_i = 16'd3; seed_valid_i = 1'b1;
        push(16'd10);
        seed_valid_i = 1'b0;
        check("seed_same_cycle", 64'(data_o), 64'd7);
        push(16'd10); check("seed_same_hist", 64'(data_o), 64'd3);

        seed(16'd0);
        ready_i = 1'b0;
        push(16'd9); check("pre_reset_data", 64'(data_o), 64'd9);
        seed_i = 16'd50; seed_valid_i = 1'b1; valid_i = 1'b1;
        do_reset();
        seed_valid_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        check("mid_reset_valid", 64'(valid_o), 64'd0);
        check("mid_reset_data",  64'(data_o),  64'd0);
        check("mid_reset_count", 64'(count_o), 64'd0);
        check("mid_reset_ready", 64'(ready_o), 64'd1);
        push(16'd4); check("post_reset", 64'(data_o), 64'd4);

        // Round trip: random x through a sum filter, back through the DUT.
        begin
            logic [WIDTH-1:0] prev;
            int in_idx, out_idx, cycles;
            logic in_x, out_x;
            logic [WIDTH-1:0] obs;
            prev = '0;
            for (int i = 0; i < N_RT; i++) begin
                xs[i] = WIDTH'($urandom);
                ys[i] = xs[i] + prev;
                prev  = xs[i];
            end
            do_reset();
            in_idx = 0; out_idx = 0; cycles = 0;
            while (out_idx < N_RT && cycles < 20000) begin
                valid_i = (in_idx < N_RT) && ($urandom_range(0, 3) != 0);
                data_i  = (in_idx < N_RT) ? ys[in_idx] : '0;
                ready_i = ($urandom_range(0, 3) != 0);
                #1;
                in_x  = valid_i && ready_o;
                out_x = valid_o && ready_i;
                obs   = data_o;
                tick();
                cycles++;
                if (out_x) begin
                    check("roundtrip", 64'(obs), 64'(xs[out_idx]));
                    out_idx++;
                end
                if (in_x) in_idx++;
            end
            valid_i = 1'b0;
            check("roundtrip_done", 64'(out_idx), 64'(N_RT));
            check("roundtrip_count", 64'(count_o), 64'(N_RT));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sum_unfilter.md
SUM_UNFILTER -- requirements
Module: sum_unfilter

Interface
REQ-001 Parameter WIDTH, default 16, sample width in bits.
REQ-002 Parameter CNT_W, default 32, width of the accepted-sample counter.
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 data_i  input  WIDTH  two-tap-summed sample y[n] = x[n] + x[n-1], modulo 2^WIDTH.
REQ-006 valid_i  input  1  data_i is valid this cycle.
REQ-007 ready_o  output  1  block accepts data_i this cycle.
REQ-008 data_o  output  WIDTH  recovered sample x[n].
REQ-009 valid_o  output  1  data_o is valid.
REQ-010 ready_i  input  1  downstream accepts data_o this cycle.
REQ-011 seed_i  input  WIDTH  history value to load as x[n-1].
REQ-012 seed_valid_i  input  1  load seed_i into history this cycle.
REQ-013 count_o  output  CNT_W  number of samples accepted since reset.

Function
REQ-014 The block SHALL compute x[n] = y[n] - x[n-1] modulo 2^WIDTH, the bit-exact inverse of the two-tap sum filter.
REQ-015 Internal history register hist SHALL hold the last recovered x; value 0 after reset, matching the sum filter's reset history.
REQ-016 Transfer in SHALL occur on a cycle with valid_i && ready_o; transfer out on valid_o && ready_i.
REQ-017 ready_o SHALL equal !valid_o || ready_i (single output register, no skid buffer).
REQ-018 Output state machine: EMPTY (valid_o=0) and FULL (valid_o=1); EMPTY->FULL on input transfer; FULL->EMPTY on output transfer without input transfer; FULL->FULL on simultaneous transfers.
REQ-019 On input transfer, data_o and hist SHALL both load data_i - h, where h is the history in effect; latency data_i to data_o one cycle.
REQ-020 data_o SHALL hold its value unchanged while valid_o=1 and ready_i=0.
REQ-021 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation, no overflow flag.
REQ-022 seed_valid_i=1 without input transfer SHALL load hist <= seed_i; data_o/valid_o unchanged.
REQ-023 seed_valid_i=1 with simultaneous input transfer SHALL use h = seed_i; hist then loads data_i - seed_i.
REQ-024 count_o SHALL increment by 1 per input transfer and wrap to 0 at 2^CNT_W; seeding does not affect it.
REQ-025 valid_i with ready_o=0 SHALL not alter hist, count_o or data_o.

Reset
REQ-026 rst_i=1 at a clock edge SHALL set hist=0, data_o=0, valid_o=0, count_o=0, state EMPTY, overriding all other inputs including seed_valid_i.
REQ-027 Reset mid-stream SHALL discard any pending output; ready_o=1 in the first cycle after reset deasserts.

Structure
REQ-028 No shared package required; WIDTH and CNT_W are the only constants, passed as parameters.
REQ-029 Single flat module; no sub-module.

Verification
REQ-030 Reset, WIDTH=16, ready_i=1, y = 5, 12, 20 -> data_o = 5, 7, 13 each one cycle after input; count_o=3.
REQ-031 Wrap: hist=0x0001, y=0x0000 -> data_o=0xFFFF; then y=0x0005 -> data_o=0x0006.
REQ-032 Backpressure: FULL with data_o=7, ready_i=0 for 4 cycles while valid_i=1 -> ready_o=0, data_o=7 held, count_o unchanged; ready_i=1 -> next sample accepted.
REQ-033 Seed: seed_i=3 alone, then y=10 -> data_o=7; seed_i=3 and y=10 same cycle -> data_o=7.
REQ-034 Reset asserted while FULL with hist=9 -> valid_o=0, data_o=0, count_o=0; next y=4 -> data_o=4.
REQ-035 Round trip: 1000 random x through the sum filter, then this block with random valid_i/ready_i -> output equals x exactly, in order.
